// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Fixed 33-cycle latency for MULT/MULTU/DIV/DIVU; MTHI/MTLO single cycle.
module mult_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  mq;
  logic [XLEN-1:0]  dvs;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  logic            is_md;
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN:0]   div_rem;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic              dz;

  // Operand decode: magnitudes and signs at issue
  always_comb begin
    is_md = ~op[2];
    sgn   = ~op[0];
    a_neg = sgn & rs_data[XLEN-1];
    b_neg = sgn & rt_data[XLEN-1];
    a_mag = a_neg ? -rs_data : rs_data;
    b_mag = b_neg ? -rt_data : rt_data;
  end

  // One radix-2 step of either shift-add or restoring division
  always_comb begin
    mul_sum = {1'b0, acc}
            + (mq[0] ? {1'b0, dvs} : '0);
    div_sh  = {acc, mq[XLEN-1]};
    div_ge  = div_sh >= {1'b0, dvs};
    div_rem = div_ge ? div_sh - {1'b0, dvs}
                     : div_sh;
  end

  // Sign correction of the unsigned result
  always_comb begin
    prod   = {acc, mq};
    prod_s = neg_q ? -prod : prod;
    dz     = dvs == '0;
    q_s    = dz ? '1 : (neg_q ? -mq : mq);
    r_s    = neg_r ? -acc : acc;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && is_md) state_nx = RUN;
      RUN:  if (cnt == CNT_W'(XLEN-1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = state != IDLE;

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      dvs    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              is_md: begin
                acc    <= '0;
                mq     <= a_mag;
                dvs    <= b_mag;
                cnt    <= '0;
                is_div <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
              end
              (op == 3'b100): hi <= rs_data;
              (op == 3'b101): lo <= rs_data;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div)
            {acc, mq} <= {div_rem[XLEN-1:0],
                          mq[XLEN-2:0], div_ge};
          else
            {acc, mq} <= {mul_sum, mq[XLEN-1:1]};
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            lo <= q_s;
            hi <= r_s;
          end else begin
            {hi, lo} <= prod_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit.
// Reference model uses plain 64-bit arithmetic.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  logic [31:0] mhi;
  logic [31:0] mlo;

  mult_div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin
        p = 64'(sa * sb);
        {mhi, mlo} = p;
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        {mhi, mlo} = p;
      end
      3'd2, 3'd3: begin
        if (b == 0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = a;
        end else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          mlo = q[31:0];
          mhi = r[31:0];
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge where done is seen
  // (or after the budget). inj>0 pulses MTHI at that cycle.
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int inj);
    int cyc, busyc, bad;
    logic [31:0] ohi, olo;
    ohi = mhi;
    olo = mlo;
    start = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    if (o[2]) begin
      model(o, a, b);
      check("mt_hi", hi, mhi);
      check("mt_lo", lo, mlo);
      check("mt_bd", {busy, done}, 0);
      return;
    end
    cyc = 1;
    busyc = 0;
    bad = 0;
    while (!done && cyc < 100) begin
      start = 1'b0;
      if (busy) busyc++;
      if (hi !== ohi || lo !== olo) bad++;
      if (cyc == inj) begin
        start = 1'b1;
        op = 3'b100;
        rs_data = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    model(o, a, b);
    check("latency", cyc - 1, 33);
    check("busy_cyc", busyc, 33);
    check("hold", bad, 0);
    check("res_hi", hi, mhi);
    check("res_lo", lo, mlo);
    check("busy_done", busy, 0);
  endtask

  logic [31:0] corner [8];

  initial begin
    int k;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    checks = 0;
    failures = 0;
    mhi = 0;
    mlo = 0;
    corner[0] = 32'h0;
    corner[1] = 32'h1;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    corner[5] = 32'h2;
    corner[6] = 32'hFFFF_FFFE;
    corner[7] = 32'h7;
    rst_n = 1'b0;
    start = 1'b0;
    op = 3'b111;
    rs_data = 0;
    rt_data = 0;
    repeat (3) @(negedge clk);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_bd", {busy, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFE, 32'h3, 0);
    check("mult_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    check("done_pulse", done, 0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(3'd2, 32'hFFFF_FFF9, 32'h2, 0);
    check("div_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'd100, 32'd7, 0);
    check("divu_val", {hi, lo}, {32'd2, 32'd14});
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(3'd3, 32'd5, 32'd0, 0);
    check("divu_z", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    issue(3'd2, 32'hFFFF_FFF0, 32'd0, 0);

    @(negedge clk);
    issue(3'd4, 32'h1234_5678, 0, 0);
    issue(3'd5, 32'h9ABC_DEF0, 0, 0);
    check("mt_pair", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    issue(3'd6, 32'h5555_5555, 0, 0);

    issue(3'd0, 32'h0001_0000, 32'hFFFF_0000, 5);
    issue(3'd1, 32'hABCD_1234, 32'h0000_FFFF, 0);

    start = 1'b1;
    op = 3'd3;
    rs_data = 32'hFFFF_0000;
    rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_hilo", {hi, lo}, 0);
    check("abort_busy", busy, 0);
    mhi = 0;
    mlo = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd1, 32'h1234_5678, 32'h8765_4321, 0);

    for (k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0)
         ? corner[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 3) == 0)
         ? corner[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 4) == 0)
        rb = rb & 32'h0000_00FF;
      issue(ro, ra, rb, (k % 7 == 0) ? 12 : 0);
      if (k % 3 == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
